uart_cmd_parser: RTL and testbench

Host-to-board command decoder for the ASCII hex telemetry link. It consumes bytes from the existing UART receiver (data plus one-cycle ready strobe). It parses framed hex commands and emits register-write and register-read strobes toward the board control logic. It is the inbound counterpart of the hex-ASCII telemetry formatter; digit rules are the inverse of its nibble-to-ASCII mapping.

---
 rtl/uart_cmd_parser_pkg.sv | 48 ++++
 rtl/uart_cmd_parser_hex_ascii_decode.sv | 26 ++
 rtl/uart_cmd_parser.sv | 189 ++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// uart_cmd_parser_pkg
//   Shared definitions for the ASCII hex command link:
//   ASCII constants, parser state encodings and err_code values.
//   Optional feature macro: UART_CMD_CHECKSUM_EN (adds the CSUM states).
package uart_cmd_parser_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_W_UC = 8'h57;
  localparam logic [7:0] ASCII_W_LC = 8'h77;
  localparam logic [7:0] ASCII_R_UC = 8'h52;
  localparam logic [7:0] ASCII_R_LC = 8'h72;

  localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_CSUM     = 2'd3;

  // state    | meaning
  // IDLE     | between frames, waiting for a command letter
  // ADDR_HI  | expecting address high nibble
  // ADDR_LO  | expecting address low nibble
  // DATA_HI  | expecting data high nibble (write only)
  // DATA_LO  | expecting data low nibble (write only)
  // CSUM_HI  | expecting checksum high nibble (checksum build only)
  // CSUM_LO  | expecting checksum low nibble (checksum build only)
  // TERM     | expecting CR or LF to execute
  // SYNC     | recovering from a bad byte, discarding until CR or LF
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR_HI = 4'd1,
    ST_ADDR_LO = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_TERM    = 4'd5,
    ST_SYNC    = 4'd6
`ifdef UART_CMD_CHECKSUM_EN
    ,
    ST_CSUM_HI = 4'd7,
    ST_CSUM_LO = 4'd8
`endif
  } state_e;

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_hex_ascii_decode.sv
// hex_ascii_decode
//   Combinational ASCII hex digit decoder (0-9, A-F, a-f).
//   Ports: byte_i   - received byte
//          nibble_o - decoded value, 0 when not a hex digit
//          is_hex_o - byte is a valid hex digit
module hex_ascii_decode (
  input  logic [7:0] byte_i,
  output logic [3:0] nibble_o,
  output logic       is_hex_o
);

  always_comb begin
    nibble_o = 4'h0;
    is_hex_o = 1'b0;
    if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
      nibble_o = byte_i[3:0];
      is_hex_o = 1'b1;
    end else if ((byte_i >= 8'h41 && byte_i <= 8'h46) ||
                 (byte_i >= 8'h61 && byte_i <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them to 10
      nibble_o = byte_i[3:0] + 4'd9;
      is_hex_o = 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Decodes framed ASCII hex commands from the UART receiver:
//     'W' AH AL DH DL term -> wr_en strobe with wr_addr/wr_data
//     'R' AH AL term       -> rd_req strobe with rd_addr
//   Bad bytes, inter-byte timeout and (optionally) checksum failures raise err.
//   Optional feature macro: UART_CMD_CHECKSUM_EN (two checksum digits before term).
//   Ports: clk, rst (sync, active-high), rx_ready/rx_data (byte in),
//          wr_en/wr_addr/wr_data, rd_req/rd_addr, err/err_code, cmd_cnt.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TMR_W          = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] cmd_cnt
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

`ifdef UART_CMD_CHECKSUM_EN
  localparam state_e ST_AFTER_DIGITS = ST_CSUM_HI;
`else
  localparam state_e ST_AFTER_DIGITS = ST_TERM;
`endif

  state_e           state_q;
  logic             op_wr_q;
  logic [7:0]       addr_q;
  logic [7:0]       data_q;
  logic [TMR_W-1:0] tmr_q;
  logic             wr_en_q, rd_req_q, err_q;
  logic [7:0]       wr_addr_q, wr_data_q, rd_addr_q, cmd_cnt_q;
  logic [1:0]       err_code_q;

  logic [3:0]       rx_nib;
  logic             rx_is_hex;

  hex_ascii_decode u_hex (
    .byte_i   (rx_data),
    .nibble_o (rx_nib),
    .is_hex_o (rx_is_hex)
  );

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       csum_ok;
  assign csum_ok = (csum_q == (op_wr_q ? (addr_q ^ data_q) : addr_q));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      tmr_q      <= '0;
      wr_en_q    <= 1'b0;
      rd_req_q   <= 1'b0;
      err_q      <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      err_code_q <= '0;
      cmd_cnt_q  <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      wr_en_q  <= 1'b0;
      rd_req_q <= 1'b0;
      err_q    <= 1'b0;
      // A byte always wins over a coincident timer expiry
      if (rx_ready) begin
        tmr_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (rx_data == ASCII_W_UC || rx_data == ASCII_W_LC) begin
              op_wr_q <= 1'b1;
              state_q <= ST_ADDR_HI;
            end else if (rx_data == ASCII_R_UC || rx_data == ASCII_R_LC) begin
              op_wr_q <= 1'b0;
              state_q <= ST_ADDR_HI;
            end else if (!(is_term(rx_data) || rx_data == ASCII_SP)) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_BAD_CHAR;
              state_q    <= ST_SYNC;
            end
          end
          ST_TERM: begin
            if (is_term(rx_data)) begin
              state_q <= ST_IDLE;
`ifdef UART_CMD_CHECKSUM_EN
              if (!csum_ok) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_CSUM;
              end else
`endif
              if (op_wr_q) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= data_q;
                cmd_cnt_q <= cmd_cnt_q + 8'd1;
              end else begin
                rd_req_q  <= 1'b1;
                rd_addr_q <= addr_q;
                cmd_cnt_q <= cmd_cnt_q + 8'd1;
              end
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_BAD_CHAR;
              state_q    <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            if (is_term(rx_data)) state_q <= ST_IDLE;
          end
          default: begin
            // remaining states all expect a hex digit
            if (!rx_is_hex) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_BAD_CHAR;
              state_q    <= ST_SYNC;
            end else begin
              case (state_q)
                ST_ADDR_HI: begin
                  addr_q  <= {addr_q[3:0], rx_nib};
                  state_q <= ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                  addr_q  <= {addr_q[3:0], rx_nib};
                  state_q <= op_wr_q ? ST_DATA_HI : ST_AFTER_DIGITS;
                end
                ST_DATA_HI: begin
                  data_q  <= {data_q[3:0], rx_nib};
                  state_q <= ST_DATA_LO;
                end
                ST_DATA_LO: begin
                  data_q  <= {data_q[3:0], rx_nib};
                  state_q <= ST_AFTER_DIGITS;
                end
`ifdef UART_CMD_CHECKSUM_EN
                ST_CSUM_HI: begin
                  csum_q  <= {csum_q[3:0], rx_nib};
                  state_q <= ST_CSUM_LO;
                end
                ST_CSUM_LO: begin
                  csum_q  <= {csum_q[3:0], rx_nib};
                  state_q <= ST_TERM;
                end
`endif
                default: state_q <= ST_IDLE;
              endcase
            end
          end
        endcase
      end else if (state_q != ST_IDLE && state_q != ST_SYNC) begin
        if (tmr_q == TMR_LAST) begin
          err_q      <= 1'b1;
          err_code_q <= ERR_TIMEOUT;
          state_q    <= ST_IDLE;
          tmr_q      <= '0;
        end else begin
          tmr_q <= tmr_q + TMR_W'(1);
        end
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_req   = rd_req_q;
  assign rd_addr  = rd_addr_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign cmd_cnt  = cmd_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
//   Randomized frame-level stimulus against a frame-outcome reference model.
//   Build with +define+UART_CMD_CHECKSUM_EN to exercise checksum frames.
module tb_uart_cmd_parser;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       wr_en, rd_req, err;
  logic [7:0] wr_addr, wr_data, rd_addr, cmd_cnt;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO), .TMR_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .err      (err),
    .err_code (err_code),
    .cmd_cnt  (cmd_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  // reference model: held outputs and expected strobe totals
  logic [7:0] exp_wa = 0, exp_wd = 0, exp_ra = 0, exp_cnt = 0;
  logic [1:0] exp_code = 0;
  int exp_wr = 0, exp_rd = 0, exp_err = 0;
  int obs_wr = 0, obs_rd = 0, obs_err = 0, obs_multi = 0;

  // current frame: bytes and the outcome each byte must produce
  // 0 none, 1 write, 2 read, 3 bad-char err, 4 checksum err
  logic [7:0] fq[$];
  int         fk[$];
  logic [7:0] fa, fd;
  int         fs;

  logic [7:0] badl [8] = '{8'h2F, 8'h3A, 8'h40, 8'h47, 8'h60, 8'h67, 8'h20, 8'h57};

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en)  obs_wr++;
      if (rd_req) obs_rd++;
      if (err)    obs_err++;
      if (int'(wr_en) + int'(rd_req) + int'(err) > 1) obs_multi++;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] csum_of(input bit w, input logic [7:0] a, input logic [7:0] d);
    return w ? (a ^ d) : a;
  endfunction

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return ($urandom_range(0, 1) ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction

  function automatic logic [7:0] term_c();
    return $urandom_range(0, 1) ? 8'h0D : 8'h0A;
  endfunction

  function automatic logic [7:0] noise_c();
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'h0D || b == 8'h0A);
    return b;
  endfunction

  task automatic add(input logic [7:0] b, input int k);
    fq.push_back(b);
    fk.push_back(k);
  endtask

  task automatic build_valid(input bit w, input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] cs);
    int k;
    fq.delete(); fk.delete();
    fa = a; fd = d;
    if ($urandom_range(0, 2) == 0) begin
      case ($urandom_range(0, 2))
        0: add(8'h0D, 0);
        1: add(8'h0A, 0);
        default: add(8'h20, 0);
      endcase
    end
    fs = fq.size();
    if (w) add($urandom_range(0, 1) ? 8'h57 : 8'h77, 0);
    else   add($urandom_range(0, 1) ? 8'h52 : 8'h72, 0);
    add(hexc(a[7:4]), 0);
    add(hexc(a[3:0]), 0);
    if (w) begin
      add(hexc(d[7:4]), 0);
      add(hexc(d[3:0]), 0);
    end
    k = w ? 1 : 2;
`ifdef UART_CMD_CHECKSUM_EN
    add(hexc(cs[7:4]), 0);
    add(hexc(cs[3:0]), 0);
    if (cs != csum_of(w, a, d)) k = 4;
`else
    if (cs != csum_of(w, a, d)) k = w ? 1 : 2;
`endif
    add(term_c(), k);
  endtask

  task automatic send(input logic [7:0] b, input int k, input int gap);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
    case (k)
      1: begin exp_cnt++; exp_wa = fa; exp_wd = fd; exp_wr++; end
      2: begin exp_cnt++; exp_ra = fa; exp_rd++; end
      3: begin exp_code = 2'd1; exp_err++; end
      4: begin exp_code = 2'd3; exp_err++; end
      default: ;
    endcase
    chk_eq("wr_en",    32'(wr_en),  32'(k == 1));
    chk_eq("rd_req",   32'(rd_req), 32'(k == 2));
    chk_eq("err",      32'(err),    32'(k == 3 || k == 4));
    chk_eq("wr_addr",  32'(wr_addr),  32'(exp_wa));
    chk_eq("wr_data",  32'(wr_data),  32'(exp_wd));
    chk_eq("rd_addr",  32'(rd_addr),  32'(exp_ra));
    chk_eq("err_code", 32'(err_code), 32'(exp_code));
    chk_eq("cmd_cnt",  32'(cmd_cnt),  32'(exp_cnt));
    repeat (gap) @(negedge clk);
  endtask

  task automatic play();
    for (int i = 0; i < fq.size(); i++) send(fq[i], fk[i], $urandom_range(0, 3));
  endtask

  task automatic valid_frame(input bit w);
    logic [7:0] a, d;
    a = 8'($urandom); d = 8'($urandom);
    build_valid(w, a, d, csum_of(w, a, d));
  endtask

  task automatic bad_in_frame();
    int pos;
    logic [7:0] b;
    valid_frame(1'($urandom_range(0, 1)));
    pos = $urandom_range(fs + 1, fq.size() - 1);
    if (pos == fq.size() - 1 && $urandom_range(0, 1)) b = hexc(4'($urandom));
    else b = badl[$urandom_range(0, 7)];
    while (fq.size() > pos) begin void'(fq.pop_back()); void'(fk.pop_back()); end
    add(b, 3);
    repeat ($urandom_range(0, 3)) add(noise_c(), 0);
    add(term_c(), 0);
  endtask

  task automatic bad_lead();
    logic [7:0] b;
    fq.delete(); fk.delete();
    do b = 8'($urandom);
    while (b == 8'h57 || b == 8'h77 || b == 8'h52 || b == 8'h72 ||
           b == 8'h0D || b == 8'h0A || b == 8'h20);
    add(b, 3);
    repeat ($urandom_range(0, 3)) add(noise_c(), 0);
    add(term_c(), 0);
  endtask

  // partial frame then silence; with late_byte the next byte lands in the expiry cycle
  task automatic timeout_case(input bit late_byte);
    int k;
    valid_frame(1'($urandom_range(0, 1)));
    k = $urandom_range(fs + 1, fq.size() - 1);
    for (int i = 0; i < k; i++) send(fq[i], fk[i], (i == k - 1) ? 0 : $urandom_range(0, 3));
    repeat (TO - 1) @(negedge clk);
    if (late_byte) begin
      for (int i = k; i < fq.size(); i++) send(fq[i], fk[i], $urandom_range(0, 3));
    end else begin
      chk_eq("to_quiet", 32'(err), 32'd0);
      @(negedge clk);
      exp_code = 2'd2;
      exp_err++;
      chk_eq("to_err",  32'(err),      32'd1);
      chk_eq("to_code", 32'(err_code), 32'd2);
      chk_eq("to_cnt",  32'(cmd_cnt),  32'(exp_cnt));
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs();
    chk_eq("rst_wr_en",    32'(wr_en),    32'd0);
    chk_eq("rst_wr_addr",  32'(wr_addr),  32'd0);
    chk_eq("rst_wr_data",  32'(wr_data),  32'd0);
    chk_eq("rst_rd_req",   32'(rd_req),   32'd0);
    chk_eq("rst_rd_addr",  32'(rd_addr),  32'd0);
    chk_eq("rst_err",      32'(err),      32'd0);
    chk_eq("rst_err_code", 32'(err_code), 32'd0);
    chk_eq("rst_cmd_cnt",  32'(cmd_cnt),  32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // directed frames
    build_valid(1'b1, 8'h3A, 8'h5C, csum_of(1'b1, 8'h3A, 8'h5C));
    add(8'h0A, 0);
    play();
    build_valid(1'b0, 8'h7F, 8'h00, csum_of(1'b0, 8'h7F, 8'h00));
    play();
    fq.delete(); fk.delete();
    add(8'h57, 0); add(8'h31, 0); add(8'h47, 3); add(8'h0D, 0);
    play();
    build_valid(1'b1, 8'h00, 8'h01, csum_of(1'b1, 8'h00, 8'h01));
    play();
`ifdef UART_CMD_CHECKSUM_EN
    build_valid(1'b1, 8'h12, 8'h34, 8'h26);
    play();
    build_valid(1'b1, 8'h12, 8'h34, 8'h27);
    play();
`endif
    timeout_case(1'b0);
    timeout_case(1'b1);

    // randomized mix
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin valid_frame(1'($urandom_range(0, 1))); play(); end
        4: begin bad_in_frame(); play(); end
        5: begin bad_lead(); play(); end
        6: timeout_case(1'b0);
        7: timeout_case(1'b1);
        8: begin
          logic [7:0] a, d;
          bit w;
          w = 1'($urandom_range(0, 1));
          a = 8'($urandom); d = 8'($urandom);
`ifdef UART_CMD_CHECKSUM_EN
          build_valid(w, a, d, csum_of(w, a, d) ^ 8'($urandom_range(1, 255)));
`else
          build_valid(w, a, d, csum_of(w, a, d));
`endif
          play();
        end
        default: begin
          valid_frame(1'($urandom_range(0, 1)));
          for (int i = 0; i < fq.size(); i++) send(fq[i], fk[i], 0);
        end
      endcase
    end

    // reset in the middle of a write frame
    build_valid(1'b1, 8'h12, 8'h34, csum_of(1'b1, 8'h12, 8'h34));
    for (int i = 0; i < fs + 3; i++) send(fq[i], 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    exp_wa = 0; exp_wd = 0; exp_ra = 0; exp_cnt = 0; exp_code = 0;
    repeat (2) @(negedge clk);

    // 256 reads bring the command counter back to zero
    for (int j = 0; j < 256; j++) begin
      build_valid(1'b0, 8'h00, 8'h00, csum_of(1'b0, 8'h00, 8'h00));
      play();
    end
    chk_eq("cnt_wrap", 32'(cmd_cnt), 32'd0);

    repeat (4) @(negedge clk);
    chk_eq("total_wr",  32'(obs_wr),    32'(exp_wr));
    chk_eq("total_rd",  32'(obs_rd),    32'(exp_rd));
    chk_eq("total_err", 32'(obs_err),   32'(exp_err));
    chk_eq("exclusive", 32'(obs_multi), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
